// File: rtl/alien_ctl.sv
// Alien formation controller: owns the alive map, the marching grid position and the score,
// and scans the formation one cell per clock against the player bullet.
module alien_ctl #(
  parameter int ROWS          = 4,
  parameter int COLS          = 8,
  parameter int ALIEN_WIDTH   = 32,
  parameter int ALIEN_HEIGHT  = 24,
  parameter int H_GAP         = 16,
  parameter int V_GAP         = 16,
  parameter int BULLET_WIDTH  = 32,
  parameter int BULLET_HEIGHT = 32,
  parameter int START_X       = 64,
  parameter int START_Y       = 64,
  parameter int STEP_X        = 4,
  parameter int STEP_Y        = 16,
  parameter int MOVE_DELAY    = 650000,
  parameter int HOR_PIXELS    = 640,
  parameter int VER_PIXELS    = 480,
  parameter int INVADE_Y      = VER_PIXELS - 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 bullet_active,
  input  logic [11:0]          xpos_shoot,
  input  logic [11:0]          bullet_y,
  output logic                 bullet_hit,
  output logic [11:0]          grid_x,
  output logic [11:0]          grid_y,
  output logic [ROWS*COLS-1:0] alive,
  output logic [15:0]          score,
  output logic                 all_dead,
  output logic                 invaded,
  output logic [1:0]           fsm_state
);
  localparam int N      = ROWS * COLS;
  localparam int IDXW   = (N > 1) ? $clog2(N) : 1;
  localparam int ROWW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COLW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CELL_W = ALIEN_WIDTH + H_GAP;
  localparam int CELL_H = ALIEN_HEIGHT + V_GAP;
  localparam int SPAN_W = COLS * CELL_W - H_GAP;
  localparam int SPAN_H = ROWS * CELL_H - V_GAP;

  // Handshake: bullet_active is a level from the player side; bullet_hit is raised on the
  // first overlapping live cell and held until bullet_active is seen low, then drops.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, HOLD = 2'd2} state_t;
  state_t state, state_n;

  logic [31:0] tick_cnt;
  logic        tick, march, dir_left, at_edge, reach_invade;
  logic [12:0] gx_w, gy_w;

  assign gx_w         = {1'b0, grid_x};
  assign gy_w         = {1'b0, grid_y};
  assign tick         = (tick_cnt == 32'(MOVE_DELAY));
  assign march        = tick && !invaded && !all_dead;
  assign at_edge      = dir_left ? (gx_w < 13'(STEP_X))
                                 : ((gx_w + 13'(SPAN_W) + 13'(STEP_X)) > 13'(HOR_PIXELS));
  assign reach_invade = (gy_w + 13'(SPAN_H)) >= 13'(INVADE_Y);
  assign all_dead     = (alive == '0);
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      grid_x   <= 12'(START_X);
      grid_y   <= 12'(START_Y);
      dir_left <= 1'b0;
      invaded  <= 1'b0;
    end else if (restart) begin
      tick_cnt <= '0;
      grid_x   <= 12'(START_X);
      grid_y   <= 12'(START_Y);
      dir_left <= 1'b0;
      invaded  <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
      if (reach_invade) invaded <= 1'b1;
      // A tick either drops the formation at an edge or steps it sideways, never both.
      if (march) begin
        if (at_edge) begin
          grid_y   <= grid_y + 12'(STEP_Y);
          dir_left <= !dir_left;
        end else if (dir_left) begin
          grid_x <= grid_x - 12'(STEP_X);
        end else begin
          grid_x <= grid_x + 12'(STEP_X);
        end
      end
    end
  end

  logic [11:0]     snap_bx, snap_by, snap_gx, snap_gy;
  logic [ROWW-1:0] scan_row;
  logic [COLW-1:0] scan_col;
  logic [IDXW-1:0] cur_idx;
  logic [12:0]     cell_x, cell_y, bx_w, by_w;
  logic            hit_cell, last_cell;
  logic [15:0]     points;
  logic [16:0]     score_sum;
  logic            snap_en, kill, release_hit;

  // Cell geometry uses the snapshot so a march tick mid-scan cannot tear the test.
  assign cur_idx   = IDXW'(scan_row) * IDXW'(COLS) + IDXW'(scan_col);
  assign cell_x    = {1'b0, snap_gx} + 13'(scan_col) * 13'(CELL_W);
  assign cell_y    = {1'b0, snap_gy} + 13'(scan_row) * 13'(CELL_H);
  assign bx_w      = {1'b0, snap_bx};
  assign by_w      = {1'b0, snap_by};
  assign hit_cell  = alive[cur_idx]
                  && (bx_w < cell_x + 13'(ALIEN_WIDTH))
                  && (bx_w + 13'(BULLET_WIDTH) > cell_x)
                  && (by_w < cell_y + 13'(ALIEN_HEIGHT))
                  && (by_w + 13'(BULLET_HEIGHT) > cell_y);
  assign last_cell = (cur_idx == IDXW'(N - 1));
  assign score_sum = {1'b0, score} + {1'b0, points};

  always_comb begin
    points = 16'd10;
    if (scan_row == '0) points = 16'd30;
    else if (scan_row == ROWW'(1)) points = 16'd20;
  end

  always_comb begin
    state_n     = state;
    snap_en     = 1'b0;
    kill        = 1'b0;
    release_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bullet_active && !bullet_hit) begin
          snap_en = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (!bullet_active) begin
          state_n = IDLE;
        end else if (hit_cell) begin
          kill    = 1'b1;
          state_n = HOLD;
        end else if (last_cell) begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (!bullet_active) begin
          release_hit = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bullet_hit <= 1'b0;
      alive      <= '1;
      score      <= '0;
      snap_bx    <= '0;
      snap_by    <= '0;
      snap_gx    <= '0;
      snap_gy    <= '0;
      scan_row   <= '0;
      scan_col   <= '0;
    end else if (restart) begin
      state      <= IDLE;
      bullet_hit <= 1'b0;
      alive      <= '1;
      score      <= '0;
      snap_bx    <= '0;
      snap_by    <= '0;
      snap_gx    <= '0;
      snap_gy    <= '0;
      scan_row   <= '0;
      scan_col   <= '0;
    end else begin
      state <= state_n;
      if (snap_en) begin
        snap_bx  <= xpos_shoot;
        snap_by  <= bullet_y;
        snap_gx  <= grid_x;
        snap_gy  <= grid_y;
        scan_row <= '0;
        scan_col <= '0;
      end else if (state == SCAN) begin
        if (scan_col == COLW'(COLS - 1)) begin
          scan_col <= '0;
          scan_row <= (scan_row == ROWW'(ROWS - 1)) ? '0 : scan_row + ROWW'(1);
        end else begin
          scan_col <= scan_col + COLW'(1);
        end
      end
      if (kill) begin
        alive[cur_idx] <= 1'b0;
        bullet_hit     <= 1'b1;
        score          <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
      if (release_hit) bullet_hit <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alien_ctl.sv
// Bench for alien_ctl: a shot table, randomized shots against a behavioural model of the
// formation, and hand sequences for edges, restart, asynchronous reset and invasion.
module tb_alien_ctl;
  localparam int ROWS   = 4;
  localparam int COLS   = 8;
  localparam int MD     = 4;
  localparam int BW     = 4;
  localparam int BH     = 8;
  localparam int AW     = 32;
  localparam int AH     = 24;
  localparam int CW     = 48;
  localparam int CH     = 40;
  localparam int SPAN_W = COLS * CW - 16;
  localparam int SPAN_H = ROWS * CH - 16;
  localparam int HOR    = 640;
  localparam int INV_Y  = 480 - 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        bullet_active = 1'b0;
  logic [11:0] xpos_shoot = '0;
  logic [11:0] bullet_y = '0;
  logic        bullet_hit;
  logic [11:0] grid_x, grid_y;
  logic [31:0] alive;
  logic [15:0] score;
  logic        all_dead, invaded;
  logic [1:0]  fsm_state;

  alien_ctl #(.MOVE_DELAY(MD), .BULLET_WIDTH(BW), .BULLET_HEIGHT(BH)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .bullet_active(bullet_active),
    .xpos_shoot(xpos_shoot), .bullet_y(bullet_y), .bullet_hit(bullet_hit),
    .grid_x(grid_x), .grid_y(grid_y), .alive(alive), .score(score),
    .all_dead(all_dead), .invaded(invaded), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model of the formation
  int          m_cnt, m_gx, m_gy, m_score;
  bit          m_left, m_inv;
  logic [31:0] m_alive;

  function automatic void model_reset();
    m_cnt = 0; m_gx = 64; m_gy = 64; m_left = 0; m_inv = 0;
    m_alive = '1; m_score = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || restart) begin
      model_reset();
    end else begin
      bit frozen;
      frozen = m_inv || (m_alive == 0);
      if (m_gy + SPAN_H >= INV_Y) m_inv = 1;
      if (m_cnt == MD) begin
        m_cnt = 0;
        if (!frozen) begin
          if (!m_left && (m_gx + SPAN_W + 4 > HOR)) begin m_gy += 16; m_left = 1; end
          else if (m_left && (m_gx < 4)) begin m_gy += 16; m_left = 0; end
          else m_gx += m_left ? -4 : 4;
        end
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("grid_x", grid_x, 64'(m_gx));
      check("grid_y", grid_y, 64'(m_gy));
      check("invaded", invaded, m_inv);
    end
  end

  function automatic int model_hit(int bx, int by);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int cx, cy;
        cx = m_gx + c * CW;
        cy = m_gy + r * CH;
        if (m_alive[r*COLS+c] && bx < cx + AW && bx + BW > cx && by < cy + AH && by + BH > cy)
          return r * COLS + c;
      end
    end
    return -1;
  endfunction

  function automatic int points(int idx);
    return (idx < COLS) ? 30 : (idx < 2 * COLS) ? 20 : 10;
  endfunction

  task automatic wait_hit(input int limit, output int n);
    n = 0;
    while (!bullet_hit && n < limit) begin @(negedge clk); n++; end
  endtask

  // Called at a negedge with the FSM idle; first_k is the expected cell for the first scan.
  task automatic shoot(input int bx, input int by, input int first_k, input int scans,
                       input int hold, input string tag);
    int k, lat, n_hi;
    bit seen;
    xpos_shoot = 12'(bx); bullet_y = 12'(by); bullet_active = 1'b1;
    k = first_k;
    for (int s = 0; s < scans; s++) begin
      if (s > 0) k = model_hit(bx, by);
      if (k >= 0) begin
        lat = 0; seen = 0;
        for (int i = 1; i <= k + 2 && !seen; i++) begin
          @(negedge clk);
          if (bullet_hit) begin seen = 1; lat = i; end
        end
        check({tag, " latency"}, 64'(lat), 64'(k + 2));
        m_alive[k] = 1'b0;
        m_score = (m_score + points(k) > 65535) ? 65535 : m_score + points(k);
        check({tag, " alive"}, alive, m_alive);
        check({tag, " score"}, score, 64'(m_score));
        n_hi = 0;
        for (int h = 0; h < hold; h++) begin @(negedge clk); if (bullet_hit) n_hi++; end
        check({tag, " hold"}, 64'(n_hi), 64'(hold));
        bullet_active = 1'b0;
        @(negedge clk);
        check({tag, " release"}, bullet_hit, 1'b0);
        check({tag, " idle"}, fsm_state, 2'd0);
        return;
      end
      n_hi = 0;
      for (int i = 1; i <= 33; i++) begin
        @(negedge clk);
        if (i == 1) check({tag, " scanning"}, fsm_state, 2'd1);
        if (bullet_hit) n_hi++;
      end
      check({tag, " no hit"}, 64'(n_hi), 64'd0);
      check({tag, " alive kept"}, alive, m_alive);
    end
    bullet_active = 1'b0;
    @(negedge clk);
  endtask

  typedef struct { int dx; int dy; int k; } shot_t;
  shot_t shots[13];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bx, by, gx_save, gy_save;
    shots[0]  = '{0,   0,   0};
    shots[1]  = '{0,   0,  -1};
    shots[2]  = '{32,  0,  -1};
    shots[3]  = '{44,  0,  -1};
    shots[4]  = '{45,  0,   1};
    shots[5]  = '{10,  40,  8};
    shots[6]  = '{100, 24, -1};
    shots[7]  = '{100, 33, 10};
    shots[8]  = '{144, 80, 19};
    shots[9]  = '{364, 140, 31};
    shots[10] = '{368, 0,  -1};
    shots[11] = '{116, -8, -1};
    shots[12] = '{116, -7,  2};
    model_reset();

    repeat (3) @(negedge clk);
    check("rst grid_x", grid_x, 64);
    check("rst grid_y", grid_y, 64);
    check("rst alive", alive, 32'hFFFF_FFFF);
    check("rst score", score, 0);
    check("rst bullet_hit", bullet_hit, 0);
    check("rst invaded", invaded, 0);
    check("rst all_dead", all_dead, 0);
    check("rst state", fsm_state, 2'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    n = 0;
    while (grid_y != 12'd80 && n < 2000) begin @(negedge clk); n++; end
    check("right edge drop y", grid_y, 80);
    check("right edge drop x", grid_x, 272);
    repeat (5) @(negedge clk);
    check("after right edge x", grid_x, 268);
    n = 0;
    while (grid_y != 12'd96 && n < 2000) begin @(negedge clk); n++; end
    check("left edge drop y", grid_y, 96);
    check("left edge drop x", grid_x, 0);
    repeat (5) @(negedge clk);
    check("after left edge x", grid_x, 4);

    for (int i = 0; i < 13; i++)
      shoot(m_gx + shots[i].dx, m_gy + shots[i].dy, shots[i].k, 1, $urandom_range(1, 6),
            $sformatf("shot%0d", i));

    xpos_shoot = 12'(m_gx + 3 * CW + 10); bullet_y = 12'(m_gy + 8); bullet_active = 1'b1;
    wait_hit(40, n);
    check("restart pre hit", bullet_hit, 1);
    restart = 1'b1;
    @(negedge clk);
    check("restart clears hit", bullet_hit, 0);
    check("restart alive", alive, 32'hFFFF_FFFF);
    check("restart score", score, 0);
    check("restart grid_x", grid_x, 64);
    restart = 1'b0; bullet_active = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      bx = m_gx + $urandom_range(0, SPAN_W);
      by = m_gy + $urandom_range(0, SPAN_H);
      shoot(bx, by, model_hit(bx, by), 2, $urandom_range(1, 5), $sformatf("rand%0d", i));
    end

    for (int idx = 0; idx < 32; idx++) begin
      if (m_alive[idx])
        shoot(m_gx + (idx % COLS) * CW + 14, m_gy + (idx / COLS) * CH + 8, idx, 1, 1,
              $sformatf("kill%0d", idx));
    end
    check("all_dead", all_dead, 1);
    check("all killed alive", alive, 0);
    check("total score", score, 560);
    gx_save = m_gx; gy_save = m_gy;
    repeat (30) @(negedge clk);
    check("frozen dead x", grid_x, 64'(gx_save));
    check("frozen dead y", grid_y, 64'(gy_save));

    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart2 alive", alive, 32'hFFFF_FFFF);
    check("restart2 score", score, 0);
    check("restart2 all_dead", all_dead, 0);
    check("restart2 grid_y", grid_y, 64);

    xpos_shoot = 12'(m_gx + 5 * CW + 10); bullet_y = 12'(m_gy + 8); bullet_active = 1'b1;
    wait_hit(40, n);
    check("hold pre reset", bullet_hit, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst bullet_hit", bullet_hit, 0);
    check("async rst state", fsm_state, 2'd0);
    check("async rst alive", alive, 32'hFFFF_FFFF);
    bullet_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    n = 0;
    while (!invaded && n < 10000) begin @(negedge clk); n++; end
    check("invaded set", invaded, 1);
    check("invaded grid_y", grid_y, 272);
    gx_save = m_gx;
    repeat (30) @(negedge clk);
    check("frozen invaded x", grid_x, 64'(gx_save));
    check("frozen invaded y", grid_y, 272);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
